// File: rtl/gnn_neighbor_aggregate.sv
// gnn_neighbor_aggregate: buffers node features, sums neighbours per adjacency row and streams saturated aggregates; AGG_SELF_LOOP_EN adds each node's own feature
module gnn_neighbor_aggregate #(
  parameter int NUM_NODES = 4,
  parameter int ADDR_W    = 2,
  parameter int FEAT_W    = 13,
  parameter int AGG_W     = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           z_valid,
  output logic                           z_ready,
  input  logic [ADDR_W-1:0]              z_node_id,
  input  logic signed [FEAT_W-1:0]       z4,
  input  logic signed [FEAT_W-1:0]       z5,
  input  logic signed [FEAT_W-1:0]       z6,
  input  logic signed [FEAT_W-1:0]       z7,
  input  logic [NUM_NODES*NUM_NODES-1:0] adj,
  input  logic                           agg_start,
  output logic                           a_valid,
  input  logic                           a_ready,
  output logic [ADDR_W-1:0]              a_node_id,
  output logic signed [AGG_W-1:0]        a4,
  output logic signed [AGG_W-1:0]        a5,
  output logic signed [AGG_W-1:0]        a6,
  output logic signed [AGG_W-1:0]        a7,
  output logic                           busy,
  output logic                           done
);
  localparam int ACC_W = FEAT_W + ADDR_W + 2;
  localparam logic signed [AGG_W-1:0] OMAX = {1'b0, {(AGG_W-1){1'b1}}};
  localparam logic signed [AGG_W-1:0] OMIN = {1'b1, {(AGG_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] AMAX = ACC_W'(OMAX);
  localparam logic signed [ACC_W-1:0] AMIN = ACC_W'(OMIN);
  typedef enum logic [1:0] {LOAD, ACCUM, OUT} state_t;
  state_t state;
  logic [ADDR_W-1:0] t, s;
  logic [NUM_NODES*NUM_NODES-1:0] adj_q;
  logic [NUM_NODES-1:0] mask, adj_row;
  logic signed [FEAT_W-1:0] fbuf [NUM_NODES][4];
  logic signed [FEAT_W-1:0] z_in [4];
  logic signed [ACC_W-1:0] acc [4];
  logic signed [ACC_W-1:0] acc_nx [4];
  logic signed [ACC_W-1:0] base [4];
  logic signed [AGG_W-1:0] a_nx [4];
  logic wr, take;
  // per-lane accumulate step; s==0 restarts the sum so each target starts clean
  always_comb begin
    z_in[0] = z4;
    z_in[1] = z5;
    z_in[2] = z6;
    z_in[3] = z7;
    wr = state == LOAD && z_valid && {1'b0, z_node_id} < (ADDR_W+1)'(NUM_NODES);
    adj_row = adj_q[t*NUM_NODES +: NUM_NODES];
    take = adj_row[s] && mask[s];
    for (int l = 0; l < 4; l++) begin
`ifdef AGG_SELF_LOOP_EN
      base[l] = mask[t] ? ACC_W'(fbuf[t][l]) : '0;
`else
      base[l] = '0;
`endif
      acc_nx[l] = (s == '0 ? base[l] : acc[l]) + (take ? ACC_W'(fbuf[s][l]) : '0);
      a_nx[l] = acc_nx[l] > AMAX ? OMAX : acc_nx[l] < AMIN ? OMIN : acc_nx[l][AGG_W-1:0];
    end
  end
  // feature buffer survives reset; only the mask decides what counts as loaded
  always_ff @(posedge clk) begin
    if (wr && !rst)
      for (int l = 0; l < 4; l++) fbuf[z_node_id][l] <= z_in[l];
  end
  // control: load features, walk sources per target, present each aggregate until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      mask <= '0;
      a_valid <= 1'b0;
      a_node_id <= '0;
      a4 <= '0;
      a5 <= '0;
      a6 <= '0;
      a7 <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      z_ready <= 1'b1;
      t <= '0;
      s <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          if (wr) mask[z_node_id] <= 1'b1;
          if (agg_start) begin
            adj_q <= adj;
            t <= '0;
            s <= '0;
            busy <= 1'b1;
            z_ready <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_nx;
          s <= s + 1'b1;
          if (s == ADDR_W'(NUM_NODES-1)) begin
            a4 <= a_nx[0];
            a5 <= a_nx[1];
            a6 <= a_nx[2];
            a7 <= a_nx[3];
            a_node_id <= t;
            a_valid <= 1'b1;
            state <= OUT;
          end
        end
        OUT: begin
          if (a_ready) begin
            a_valid <= 1'b0;
            s <= '0;
            if (t == ADDR_W'(NUM_NODES-1)) begin
              done <= 1'b1;
              mask <= '0;
              busy <= 1'b0;
              z_ready <= 1'b1;
              state <= LOAD;
            end else begin
              t <= t + 1'b1;
              state <= ACCUM;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_gnn_neighbor_aggregate.sv
// tb_gnn_neighbor_aggregate: scoreboard bench with a lane-sum reference model of the neighbour aggregator
module tb_gnn_neighbor_aggregate;
  localparam int N = 4, AW = 2, FW = 13, GW = 15;
  logic clk = 0, rst = 1, z_valid = 0, agg_start = 0, a_ready = 0;
  logic z_ready, a_valid, busy, done;
  logic [AW-1:0] z_node_id = '0, a_node_id;
  logic signed [FW-1:0] z4 = '0, z5 = '0, z6 = '0, z7 = '0;
  logic signed [GW-1:0] a4, a5, a6, a7;
  logic [N*N-1:0] adj = '0;
  typedef struct { int id; int v[4]; } exp_t;
  exp_t sb[$];
  int mbuf[N][4];
  bit mmask[N];
  int compared = 0, mismatched = 0, done_cnt = 0;

  gnn_neighbor_aggregate dut (
    .clk(clk), .rst(rst), .z_valid(z_valid), .z_ready(z_ready), .z_node_id(z_node_id),
    .z4(z4), .z5(z5), .z6(z6), .z7(z7), .adj(adj), .agg_start(agg_start),
    .a_valid(a_valid), .a_ready(a_ready), .a_node_id(a_node_id),
    .a4(a4), .a5(a5), .a6(a6), .a7(a7), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic int sat(input int x);
    int hi = (1 << (GW-1)) - 1;
    return x > hi ? hi : x < -hi-1 ? -hi-1 : x;
  endfunction

  function automatic int rv();
    int r = int'($urandom_range(0, 7));
    if (r == 0) return 4095;
    if (r == 1) return -4096;
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  // monitor: every presented aggregate must match the head of the scoreboard
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (a_valid) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got id %0d expected no output", a_node_id);
      end else begin
        check("a_node_id", int'(a_node_id), sb[0].id);
        check("a4", int'(a4), sb[0].v[0]);
        check("a5", int'(a5), sb[0].v[1]);
        check("a6", int'(a6), sb[0].v[2]);
        check("a7", int'(a7), sb[0].v[3]);
        if (a_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass(input logic [N*N-1:0] am);
    for (int tt = 0; tt < N; tt++) begin
      exp_t e;
      e.id = tt;
      for (int l = 0; l < 4; l++) begin
        int sum = 0;
`ifdef AGG_SELF_LOOP_EN
        if (mmask[tt]) sum = mbuf[tt][l];
`endif
        for (int ss = 0; ss < N; ss++)
          if (am[tt*N+ss] && mmask[ss]) sum += mbuf[ss][l];
        e.v[l] = sat(sum);
      end
      sb.push_back(e);
    end
    for (int i = 0; i < N; i++) mmask[i] = 0;
  endtask

  task automatic zwr(input int id, input int v0, input int v1, input int v2, input int v3,
                     input bit st, input logic [N*N-1:0] am);
    z_valid = 1;
    z_node_id = AW'(id);
    z4 = FW'(v0);
    z5 = FW'(v1);
    z6 = FW'(v2);
    z7 = FW'(v3);
    mbuf[id][0] = v0;
    mbuf[id][1] = v1;
    mbuf[id][2] = v2;
    mbuf[id][3] = v3;
    mmask[id] = 1;
    if (st) begin
      adj = am;
      agg_start = 1;
      push_pass(am);
    end
    tick();
    z_valid = 0;
    agg_start = 0;
  endtask

  task automatic start(input logic [N*N-1:0] am);
    adj = am;
    agg_start = 1;
    push_pass(am);
    tick();
    agg_start = 0;
  endtask

  // drains a started pass by hand, timing each aggregate; optional hold on node 1 and junk writes
  task automatic manual_pass(input bit hold1, input bit junk);
    int n;
    if (junk) begin
      z_valid = 1;
      z_node_id = 2'd2;
      z4 = 13'sd999;
      z5 = 13'sd999;
      z6 = 13'sd999;
      z7 = 13'sd999;
    end
    for (int t = 0; t < N; t++) begin
      n = 1;
      while (!a_valid && n < 50) begin
        tick();
        n++;
      end
      check("latency", n, 5);
      check("busy_in_pass", int'(busy), 1);
      check("z_ready_in_pass", int'(z_ready), 0);
      if (hold1 && t == 1) repeat (7) tick();
      if (t == N-1) z_valid = 0;
      a_ready = 1;
      tick();
      a_ready = 0;
    end
    check("done_pulse", int'(done), 1);
    tick();
    check("done_low", int'(done), 0);
    check("z_ready_after", int'(z_ready), 1);
    check("busy_after", int'(busy), 0);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int n, nw, d0;
    logic [N*N-1:0] ring, am;
    repeat (3) tick();
    check("rst_a_valid", int'(a_valid), 0);
    check("rst_z_ready", int'(z_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_a_node_id", int'(a_node_id), 0);
    check("rst_a4", int'(a4), 0);
    rst = 0;
    tick();
    ring = '0;
    for (int t = 0; t < N; t++) begin
      ring[t*N+(t+1)%N] = 1'b1;
      ring[t*N+(t+N-1)%N] = 1'b1;
    end
    for (int i = 0; i < N; i++) zwr(i, 10*(i+1), 10*(i+1), 10*(i+1), 10*(i+1), 0, '0);
    start(ring);
    manual_pass(0, 0);
    for (int i = 0; i < N; i++) zwr(i, 4095, 4095, 4095, 4095, 0, '0);
    start('1);
    manual_pass(0, 0);
    zwr(2, 100, -5, 7, 3000, 0, '0);
    zwr(2, -4096, -4096, -4096, -4096, 0, '0);
    zwr(0, 0, 0, 0, 0, 0, '0);
    zwr(1, 0, 0, 0, 0, 0, '0);
    zwr(3, 0, 0, 0, 0, 0, '0);
    start(16'h0004);
    manual_pass(0, 0);
    for (int i = 0; i < N; i++) zwr(i, -4096, -4096, -4096, -4096, 0, '0);
    start('1);
    manual_pass(0, 0);
    for (int i = 0; i < N; i++) zwr(i, rv(), rv(), rv(), rv(), 0, '0);
    start(ring);
    manual_pass(1, 0);
    zwr(0, rv(), rv(), rv(), rv(), 0, '0);
    zwr(1, rv(), rv(), rv(), rv(), 0, '0);
    start('1);
    manual_pass(0, 1);
    for (int i = 0; i < N-1; i++) zwr(i, rv(), rv(), rv(), rv(), 0, '0);
    zwr(3, rv(), rv(), rv(), rv(), 1, '1);
    manual_pass(0, 0);
    for (int i = 0; i < N; i++) zwr(i, rv(), rv(), rv(), rv(), 0, '0);
    start('1);
    n = 0;
    while (!(a_valid && a_node_id == 2'd2) && n < 100) begin
      a_ready = a_valid;
      tick();
      a_ready = 0;
      n++;
    end
    check("reach_node2", int'(a_valid && a_node_id == 2'd2), 1);
    rst = 1;
    tick();
    rst = 0;
    check("abort_a_valid", int'(a_valid), 0);
    check("abort_z_ready", int'(z_ready), 1);
    check("abort_busy", int'(busy), 0);
    sb.delete();
    zwr(1, rv(), rv(), rv(), rv(), 0, '0);
    start('1);
    manual_pass(0, 0);
    for (int p = 0; p < 20; p++) begin
      nw = int'($urandom_range(0, 6));
      am = (N*N)'($urandom);
      for (int i = 0; i < nw; i++) zwr(int'($urandom_range(0, N-1)), rv(), rv(), rv(), rv(), 0, '0);
      if ($urandom_range(0, 1) == 1) zwr(int'($urandom_range(0, N-1)), rv(), rv(), rv(), rv(), 1, am);
      else start(am);
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < 300) begin
        a_ready = 1'($urandom);
        tick();
        n++;
      end
      a_ready = 0;
      repeat (2) tick();
      check("rand_done_once", done_cnt - d0, 1);
      check("rand_sb_empty", sb.size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
